// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// Operands are latched on accept; the result commits to HI/LO when the busy countdown expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [1:0]    op_q;

  logic          signed_op;
  logic          neg_a;
  logic          neg_b;
  logic [63:0]   ext_a;
  logic [63:0]   ext_b;
  logic [63:0]   product;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   quot;
  logic [31:0]   rem;

  // op_q[0] selects unsigned; signed division works on magnitudes so the
  // 0x80000000 / -1 case falls out naturally instead of overflowing.
  always_comb begin
    signed_op = ~op_q[0];
    neg_a     = signed_op & a_q[31];
    neg_b     = signed_op & b_q[31];
    ext_a     = {{32{neg_a}}, a_q};
    ext_b     = {{32{neg_b}}, b_q};
    product   = ext_a * ext_b;
    mag_a     = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b     = neg_b ? (~b_q + 32'd1) : b_q;
    uq        = 32'd0;
    ur        = 32'd0;
    if (mag_b != 32'd0) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quot = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem  = neg_a ? (~ur + 32'd1) : ur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op[1:0];
                cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state <= BUSY;
                busy  <= 1'b1;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            // Divide by zero still spends the full latency but leaves HI/LO alone.
            if (!op_q[1]) begin
              HI <= product[63:32];
              LO <= product[31:0];
            end else if (b_q != 32'd0) begin
              HI <= rem;
              LO <= quot;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
